// File: rtl/router_pkg.sv
// Shared router types and constants: arbiter state encoding and default port count.
package router_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int NUM_PORTS = 4;

endpackage

// File: rtl/output_rr_arbiter_if.sv
// Request/grant bundle between input-port request logic and the output arbiter.
interface output_rr_arbiter_if
    import router_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_tail;
    logic               isfull;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   owner_idx;
    logic               locked;

    modport master (
        output req, req_tail, isfull,
        input  grant, grant_valid, owner_idx, locked
    );

    modport slave (
        input  req, req_tail, isfull,
        output grant, grant_valid, owner_idx, locked
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit at or above the one-hot prio position, wrapping around.
module rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     prio,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;

    // Low half holds requests at/above prio; high half is the full vector for the wrap case.
    always_comb begin
        dbl    = {req, req & ~(prio - N'(1))};
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !any) begin
                any            = 1'b1;
                winner[i % N]  = 1'b1;
                idx            = IDX_W'(i % N);
            end
        end
    end

endmodule

// File: rtl/output_rr_arbiter.sv
// Round-robin output arbiter with packet locking: owner keeps the output until its tail flit.
module output_rr_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS
) (
    input  logic                clk,
    input  logic                reset,
    output_rr_arbiter_if.slave  arb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] prio_q;
    logic [IDX_W-1:0]   owner_q;

    logic [NUM_REQ-1:0] pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   idx_c;
    logic               xfer;
    logic               tail_xfer;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (arb.req),
        .prio   (prio_q),
        .winner (pick_winner),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        if (state_q == ARB_IDLE) begin
            if (pick_any) begin
                idx_c = pick_idx;
                if (!arb.isfull) grant_c = pick_winner;
            end
        end else begin
            idx_c = owner_q;
            if (arb.req[owner_q] && !arb.isfull) grant_c[owner_q] = 1'b1;
        end
        xfer      = |grant_c;
        tail_xfer = |(grant_c & arb.req_tail);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            prio_q  <= NUM_REQ'(1);
            owner_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (xfer && !tail_xfer) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= pick_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (tail_xfer) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
            // Winner drops to lowest priority only once its packet has completed.
            if (tail_xfer) prio_q <= {grant_c[NUM_REQ-2:0], grant_c[NUM_REQ-1]};
        end
    end

    assign arb.grant       = grant_c;
    assign arb.grant_valid = xfer;
    assign arb.owner_idx   = idx_c;
    assign arb.locked      = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_output_rr_arbiter.sv
// Scoreboard bench for output_rr_arbiter: directed per-cycle vectors, monitor compares on negedge.
module tb_output_rr_arbiter;

    logic clk;
    logic reset;

    output_rr_arbiter_if #(.NUM_REQ(4)) intf ();

    output_rr_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic       locked;
        logic [1:0] idx;
        bit         chk_idx;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%b required=%b", name, act, exp);
    endtask

    // Monitor: one expected entry per stimulus cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({e.name, ".grant"}, intf.grant, e.grant);
                cmp({e.name, ".grant_valid"}, {3'b000, intf.grant_valid}, {3'b000, |e.grant});
                cmp({e.name, ".locked"}, {3'b000, intf.locked}, {3'b000, e.locked});
                if (e.chk_idx) cmp({e.name, ".owner_idx"}, {2'b00, intf.owner_idx}, {2'b00, e.idx});
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic [3:0] rq,
                        input logic [3:0] tl, input logic full, input logic [3:0] g,
                        input logic lk, input logic [1:0] ix, input bit ci);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        intf.req      = rq;
        intf.req_tail = tl;
        intf.isfull   = full;
        e.grant   = g;
        e.locked  = lk;
        e.idx     = ix;
        e.chk_idx = ci;
        e.name    = name;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        intf.req      = '0;
        intf.req_tail = '0;
        intf.isfull   = 1'b0;
        repeat (2) @(posedge clk);

        //    name      rst   req      tail     full  grant    lk    idx  chk
        step("rst0",   1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
        step("rst1",   1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
        step("rst2",   1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
        // single-flit contention, full rotation
        step("rr0",    1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 1);
        step("rr1",    1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd1, 1);
        step("rr2",    1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd2, 1);
        step("rr3",    1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd3, 1);
        // packet lock on requester 0 (wrap back to 0)
        step("lk0",    1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1);
        step("lk1",    1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1);
        step("lk2",    1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1);
        step("lk3",    1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1);
        // backpressure while owner 1 holds the lock
        step("bp0",    1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1);
        step("bp1",    1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1);
        step("bp2",    1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1);
        step("bp3",    1'b0, 4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1);
        // owner 2 bubble; stray tail without req is ignored
        step("bub0",   1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1);
        step("bub1",   1'b0, 4'b1001, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1);
        step("bub2",   1'b0, 4'b1101, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1);
        // isfull in IDLE: nothing granted, no state change
        step("full0",  1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 0);
        // owner 3 locked, then reset mid-packet
        step("mr0",    1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd3, 1);
        step("mr1",    1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1);
        step("mr2",    1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1);
        step("mr3",    1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/output_rr_arbiter.md
Name: output_rr_arbiter

Overview:
- Parametrised successor of the router's 4-input output arbiter: NUM_REQ input-port requesters contend for one output buffer.
- Holds its own rotating round-robin priority, replacing the externally supplied priority value and change-priority strobe.
- Adds packet locking: a granted requester keeps the output until its tail flit transfers, so multi-flit packets are never interleaved.
- Sits between the input-port request logic and the output FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- IDX_W, $clog2(NUM_REQ), width of the owner index output (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester flit-valid request.
- req_tail  input  NUM_REQ  per-requester "current flit is last of packet"; sampled only with req.
- isfull  input  1  output buffer full; no transfer while high.
- grant  output  NUM_REQ  one-hot (or zero) grant; a flit transfers when grant[i] is high.
- grant_valid  output  1  OR of grant.
- owner_idx  output  IDX_W  binary index of current winner/owner; 0 when none.
- locked  output  1  high while a packet is in progress (state LOCKED).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State: fsm in {IDLE, LOCKED}; prio_q one-hot NUM_REQ; owner_q IDX_W.
- Reset values: fsm=IDLE, prio_q=bit0 set, owner_q=0. Outputs after reset: grant=0, grant_valid=0, owner_idx=0, locked=0.
- grant, grant_valid and owner_idx are combinational from state and inputs (zero-cycle grant, as in the previous generation). locked is a decode of fsm.
- Winner pick: first requester with req set, searching circularly from the prio_q bit position upward with wrap-around.
  - Example: prio_q=0100, req=1011 -> winner 3.
  - Example: prio_q=1000, req=0011 -> winner 0.
- IDLE:
  - grant = onehot(winner) when (|req) && !isfull, else 0.
  - Transfer of a flit with req_tail set: stay IDLE (single-flit packet).
  - Transfer without req_tail: go to LOCKED, owner_q <= winner.
- LOCKED:
  - grant[owner_q] = req[owner_q] && !isfull; all other grant bits are 0.
  - Requests from non-owners are ignored.
  - The owner may drop req mid-packet (bubble): the lock holds and grant is 0 that cycle.
  - Owner transfer with req_tail set: go to IDLE.
- Priority rotation: on every tail transfer (IDLE or LOCKED), prio_q <= rotate-left-by-1 of the grant vector, so the winner becomes lowest priority. prio_q is otherwise unchanged, including for a lone requester with no tail, while isfull is high, and during body flits.
- isfull high: grant=0 and no state change. In IDLE the winner is re-evaluated each cycle; a request not yet granted may be overtaken.
- Invariants:
  - At most one grant bit set.
  - No grant while isfull is high.
  - grant[i] implies req[i].
  - prio_q is always one-hot.
- reset asserted mid-packet: lock is abandoned and everything returns to reset values on the next edge. reset has priority over all other updates.
- req_tail without req: ignored.

Decomposition:
- Shared package (router_pkg): arb_state_e enum {ARB_IDLE, ARB_LOCKED}; default requester-count constant NUM_PORTS=4.
- One combinational sub-module, rr_pick: inputs req and one-hot prio; outputs one-hot winner, binary index and any. It is implemented as a double-width masked priority encoder and is reusable by the input-side VC allocator.

Test Plan (NUM_REQ=4):
- Reset, then req=0000 for 3 cycles -> grant=0000, locked=0, owner_idx=0, prio_q=0001.
- Single-flit contention: req=1111, req_tail=1111 held for 4 cycles, isfull=0 -> grants 0001, 0010, 0100, 1000 in order, then wraps to 0001; locked stays 0.
- Packet lock: req=0011; requester 0 sends 3 flits with tail on the 3rd -> grant=0001 for 3 cycles, locked=1 for cycles 2-3; grant=0010 on the 4th cycle.
- Backpressure mid-packet: owner 1 locked, isfull=1 for 2 cycles -> grant=0000 and locked=1 throughout; on isfull=0 grant=0010 resumes with the same owner and no switch to other requesters.
- Owner bubble: owner 2 locked, req[2]=0 for 1 cycle while req=1001 -> grant=0000 that cycle; the lock holds and requesters 0 and 3 are not granted.
- Reset mid-packet: owner 3 locked after 1 body flit, reset pulsed -> next cycle locked=0, prio_q=0001; with req=1010 -> grant=0010.
